// File: rtl/wqe_fetch_if.sv
// Handshake and data-path bundle between the WQE fetch engine (master) and its
// scheduler / doorbell / config / DMA / cache neighbours (slave).
interface wqe_fetch_if #(
  parameter int unsigned MAX_QP       = 16,
  parameter int unsigned QP_PTR_WIDTH = 4,
  parameter int unsigned IDX_WIDTH    = 16,
  parameter int unsigned ADDR_WIDTH   = 64,
  parameter int unsigned WQE_WIDTH    = 512
);
  logic                    i_arbit_val;
  logic [QP_PTR_WIDTH-1:0] i_qp_idx;
  logic                    o_wqe_fetch_ready;
  logic [MAX_QP-1:0]       o_active;

  logic                    i_db_val;
  logic [QP_PTR_WIDTH-1:0] i_db_qp;
  logic [IDX_WIDTH-1:0]    i_db_pi;

  logic                    i_cfg_val;
  logic [QP_PTR_WIDTH-1:0] i_cfg_qp;
  logic [ADDR_WIDTH-1:0]   i_cfg_base;
  logic [3:0]              i_cfg_log_depth;

  logic                    o_dma_req_val;
  logic [ADDR_WIDTH-1:0]   o_dma_req_addr;
  logic [15:0]             o_dma_req_len;
  logic [QP_PTR_WIDTH-1:0] o_dma_req_tag;
  logic                    i_dma_req_rdy;

  logic                    i_dma_rsp_val;
  logic [WQE_WIDTH-1:0]    i_dma_rsp_data;
  logic                    i_dma_rsp_last;

  logic                    o_cache_wr_val;
  logic [QP_PTR_WIDTH-1:0] o_cache_wr_qp;
  logic [WQE_WIDTH-1:0]    o_cache_wr_data;

  logic                    o_err;

  modport master (
    input  i_arbit_val, i_qp_idx,
    output o_wqe_fetch_ready, o_active,
    input  i_db_val, i_db_qp, i_db_pi,
    input  i_cfg_val, i_cfg_qp, i_cfg_base, i_cfg_log_depth,
    output o_dma_req_val, o_dma_req_addr, o_dma_req_len, o_dma_req_tag,
    input  i_dma_req_rdy,
    input  i_dma_rsp_val, i_dma_rsp_data, i_dma_rsp_last,
    output o_cache_wr_val, o_cache_wr_qp, o_cache_wr_data,
    output o_err
  );

  modport slave (
    output i_arbit_val, i_qp_idx,
    input  o_wqe_fetch_ready, o_active,
    output i_db_val, i_db_qp, i_db_pi,
    output i_cfg_val, i_cfg_qp, i_cfg_base, i_cfg_log_depth,
    input  o_dma_req_val, o_dma_req_addr, o_dma_req_len, o_dma_req_tag,
    output i_dma_req_rdy,
    output i_dma_rsp_val, i_dma_rsp_data, i_dma_rsp_last,
    input  o_cache_wr_val, o_cache_wr_qp, o_cache_wr_data,
    input  o_err
  );
endinterface

// File: rtl/wqe_fetch_engine.sv
// WQE fetch engine: turns each scheduler grant into one bounded, wrap-free DMA ring read
// and streams the returned WQEs into the per-QP cache while tracking per-QP ring pointers.
module wqe_fetch_engine #(
  parameter int unsigned MAX_QP       = 16,
  parameter int unsigned QP_PTR_WIDTH = 4,
  parameter int unsigned IDX_WIDTH    = 16,
  parameter int unsigned ADDR_WIDTH   = 64,
  parameter int unsigned WQE_WIDTH    = 512,
  parameter int unsigned MAX_BURST    = 4
) (
  input logic         sys_clk,
  input logic         sys_rst,
  wqe_fetch_if.master bus
);
  localparam int unsigned CNT_W     = $clog2(MAX_BURST) + 1;
  localparam int unsigned DEPTH_W   = IDX_WIDTH + 1;
  localparam int unsigned LD_W      = 4;
  localparam int unsigned LEN_W     = 16;
  localparam int unsigned WQE_SHIFT = 6;

  typedef enum logic [1:0] {IDLE, CALC, REQ, RSP} state_t;

  state_t                  state;
  logic [IDX_WIDTH-1:0]    pi        [MAX_QP];
  logic [IDX_WIDTH-1:0]    fptr      [MAX_QP];
  logic [ADDR_WIDTH-1:0]   base      [MAX_QP];
  logic [LD_W-1:0]         log_depth [MAX_QP];
  logic [QP_PTR_WIDTH-1:0] qp;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        beats;
  logic                    drop_adv;
  logic                    req_val;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [LEN_W-1:0]        req_len;
  logic                    err;
  logic [MAX_QP-1:0]       active;

  logic [DEPTH_W-1:0]      depth_c, off_c, avail_c, room_c, cnt_c;
  logic [CNT_W-1:0]        beat_n;
  logic [WQE_WIDTH-1:0]    rsp_data;

  // Burst size for the latched QP: bounded by pending WQEs, MAX_BURST and distance to ring wrap
  always_comb begin
    depth_c = DEPTH_W'(1) << log_depth[qp];
    off_c   = DEPTH_W'(fptr[qp]) & (depth_c - DEPTH_W'(1));
    avail_c = DEPTH_W'(IDX_WIDTH'(pi[qp] - fptr[qp]));
    room_c  = depth_c - off_c;
    cnt_c   = avail_c;
    if (DEPTH_W'(MAX_BURST) < cnt_c) cnt_c = DEPTH_W'(MAX_BURST);
    if (room_c < cnt_c)              cnt_c = room_c;
  end

  assign beat_n   = beats + CNT_W'(1);
  assign rsp_data = bus.i_dma_rsp_data;

  assign bus.o_wqe_fetch_ready = (state == IDLE);
  assign bus.o_active          = active;
  assign bus.o_dma_req_val     = req_val;
  assign bus.o_dma_req_addr    = req_addr;
  assign bus.o_dma_req_len     = req_len;
  assign bus.o_dma_req_tag     = qp;
  assign bus.o_cache_wr_val    = (state == RSP) && bus.i_dma_rsp_val;
  assign bus.o_cache_wr_qp     = qp;
  assign bus.o_cache_wr_data   = rsp_data;
  assign bus.o_err             = err;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= IDLE;
      qp       <= '0;
      cnt      <= '0;
      beats    <= '0;
      drop_adv <= 1'b0;
      req_val  <= 1'b0;
      req_addr <= '0;
      req_len  <= '0;
      err      <= 1'b0;
      active   <= '0;
      for (int q = 0; q < int'(MAX_QP); q++) begin
        pi[q]        <= '0;
        fptr[q]      <= '0;
        base[q]      <= '0;
        log_depth[q] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_arbit_val) begin
            qp       <= bus.i_qp_idx;
            drop_adv <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          if (cnt_c == '0) begin
            state <= IDLE;
          end else begin
            cnt      <= CNT_W'(cnt_c);
            req_addr <= base[qp] + (ADDR_WIDTH'(off_c) << WQE_SHIFT);
            req_len  <= LEN_W'(cnt_c) << WQE_SHIFT;
            beats    <= '0;
            req_val  <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (bus.i_dma_req_rdy) begin
            req_val <= 1'b0;
            state   <= RSP;
          end
        end
        RSP: begin
          if (bus.i_dma_rsp_val) begin
            beats <= beat_n;
            if (bus.i_dma_rsp_last) begin
              if (beat_n != cnt) err <= 1'b1;
              if (!drop_adv) fptr[qp] <= fptr[qp] + IDX_WIDTH'(cnt);
              state <= IDLE;
            end else if (beat_n >= cnt) begin
              err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // A reconfigured ring invalidates the in-flight fetch's pointer advance
      if (bus.i_cfg_val && (state != IDLE) && (bus.i_cfg_qp == qp)) drop_adv <= 1'b1;

      if (bus.i_db_val) pi[bus.i_db_qp] <= bus.i_db_pi;

      // Placed after doorbell and fptr advance so config wins on the same edge
      if (bus.i_cfg_val) begin
        base[bus.i_cfg_qp]      <= bus.i_cfg_base;
        log_depth[bus.i_cfg_qp] <= bus.i_cfg_log_depth;
        pi[bus.i_cfg_qp]        <= '0;
        fptr[bus.i_cfg_qp]      <= '0;
      end

      for (int q = 0; q < int'(MAX_QP); q++) active[q] <= (pi[q] != fptr[q]);
    end
  end
endmodule

// File: doc/wqe_fetch_engine.md
# wqe_fetch_engine

Consumer end of the WQE read-scheduling handshake. It raises `o_wqe_fetch_ready` to the WQE read scheduler and accepts the resulting grant (`i_arbit_val`, `i_qp_idx`). It then issues one DMA read for up to `MAX_BURST` WQEs from the granted QP's send ring and streams the returned WQEs into the per-QP WQE cache. It keeps per-QP producer index, fetch pointer, ring base and depth, and derives the per-QP `o_active` vector that feeds the scheduler's `i_active`.

## Interface
- `MAX_QP`, 16, number of QPs
- `QP_PTR_WIDTH`, 4, log2(MAX_QP)
- `IDX_WIDTH`, 16, ring index width
- `ADDR_WIDTH`, 64, DMA address width
- `WQE_WIDTH`, 512, one WQE (64 B) per DMA response beat
- `MAX_BURST`, 4, maximum WQEs per fetch (power of 2)
- `sys_clk` in 1: sole clock
- `sys_rst` in 1: asynchronous, active-high reset
- `i_arbit_val` in 1: grant strobe from the scheduler
- `i_qp_idx` in QP_PTR_WIDTH: granted QP
- `o_wqe_fetch_ready` out 1: engine idle and able to take a grant
- `o_active` out MAX_QP: bit q = (pi[q] != fptr[q])
- `i_db_val`, `i_db_qp`, `i_db_pi` in 1/QP_PTR_WIDTH/IDX_WIDTH: doorbell, writes pi[q]
- `i_cfg_val`, `i_cfg_qp`, `i_cfg_base`, `i_cfg_log_depth` in 1/QP_PTR_WIDTH/ADDR_WIDTH/4: ring config; also clears pi[q] and fptr[q]
- `o_dma_req_val`, `o_dma_req_addr`, `o_dma_req_len`, `o_dma_req_tag` out 1/ADDR_WIDTH/16/QP_PTR_WIDTH: read request; len is in bytes
- `i_dma_req_rdy` in 1: request accept
- `i_dma_rsp_val`, `i_dma_rsp_data`, `i_dma_rsp_last` in 1/WQE_WIDTH/1: response beats
- `o_cache_wr_val`, `o_cache_wr_qp`, `o_cache_wr_data` out 1/QP_PTR_WIDTH/WQE_WIDTH: cache write
- `o_err` out 1: sticky beat-count mismatch flag

## Operation
- **FSM states:** IDLE, CALC, REQ, RSP.
- **Ready:** `o_wqe_fetch_ready` = (state==IDLE), decoded combinationally from the registered state.
- **IDLE:** when `i_arbit_val` is high, latch `qp` = `i_qp_idx` and go to CALC. `i_arbit_val` in any other state is ignored; the grant is dropped.
- **CALC (one cycle):**
  - depth = 2^log_depth[qp]
  - off = fptr[qp] mod depth
  - avail = (pi[qp] − fptr[qp]) mod 2^IDX_WIDTH
  - cnt = min(avail, MAX_BURST, depth − off)
  - If cnt==0, return to IDLE with no request. Otherwise register addr = base[qp] + off·64, len = cnt·64 and tag = qp, then go to REQ.
- **REQ:** hold `o_dma_req_val` with stable fields until `i_dma_req_rdy`; on that handshake go to RSP.
- **RSP:**
  - Each `i_dma_rsp_val` beat drives `o_cache_wr_val` = 1, `o_cache_wr_qp` = qp and `o_cache_wr_data` = `i_dma_rsp_data` in the same cycle (combinational pass-through), and increments the beat counter.
  - On the beat with `i_dma_rsp_last`: fptr[qp] += cnt, modulo 2^IDX_WIDTH, then go to IDLE.
  - If beats ≠ cnt at last, or the counter reaches cnt without last, set `o_err`. The engine still returns to IDLE at last and still advances fptr by cnt.
- **Cache space:** the cache raises almost-full with at least MAX_BURST free entries, so the engine does no backpressure check on writes.
- **Doorbell:** pi[db_qp] ← i_db_pi. The write is accepted in any state.
- **Config:**
  - base, log_depth, pi and fptr of cfg_qp are set and cleared on the edge.
  - If cfg_qp equals the in-flight qp, the pending fptr advance is suppressed. Response beats are still forwarded.
  - Config and doorbell to the same QP on the same edge: config wins for pi.
- **Ring wrap:** a fetch never crosses the ring wrap; the remainder is fetched on a later grant.

## Timing
- **Reset values:** state IDLE, so `o_wqe_fetch_ready` = 1. `o_dma_req_val`, `o_cache_wr_val`, `o_err` = 0. `o_active` = 0. All pi, fptr, base = 0; log_depth = 0.
- **Grant to request:** `i_arbit_val` sampled at edge t gives `o_dma_req_val` high from edge t+2 (CALC at t+1).
- **Ready deassertion:** ready drops the cycle after the grant edge. With the scheduler's one-cycle arbit pulse and two-cycle ready-to-grant latency, this guarantees no second grant while busy.
- **Last beat to ready:** last beat at edge t gives `o_wqe_fetch_ready` high from t+1.
- **`o_active` update:** registered; updates one cycle after a doorbell, config or fptr advance.
- **Async reset mid-fetch:** returns to IDLE and drops the outstanding fetch. Late DMA beats arriving in IDLE are discarded, with no cache write and no `o_err`.

## Test plan
1. **Basic fetch:** cfg QP3 base=0x1000, log_depth=4; doorbell QP3 pi=2; grant QP3 → one request addr=0x1000, len=128, tag=3. Two beats with last on beat 2 → two cache writes to qp 3, fptr=2, `o_active[3]` drops to 0, ready returns.
2. **Burst cap:** pi=10, fptr=0, depth 16 → len=256 (4 WQEs); the next three grants give len 256, 128, then no request.
3. **Ring wrap:** depth 16, fptr=14, pi=20 → first fetch addr=base+0x380, len=128; second fetch addr=base, len=256. fptr wraps correctly at 2^16 when pi=0x0002 and fptr=0xFFFE.
4. **Empty grant:** grant to a QP with pi==fptr → no `o_dma_req_val`; ready is back high 2 cycles after the grant.
5. **Busy and err:** a grant arriving during RSP is ignored. A response with last on beat 1 when cnt=2 sets `o_err` = 1, which stays set until `sys_rst`.
6. **Reset and config races:** `sys_rst` asserted in REQ → `o_dma_req_val` is 0 immediately and ready = 1. Config to the in-flight QP during RSP → fptr stays 0 after last.
